dc_ipu_filter_core_s0: RTL and testbench
========================================

// Module: dc_ipu_filter_core_s0
// PURPOSE
//  Front stage of the IPU scaler filter: takes a 4x4 texel neighbourhood plus per-axis tap weights,
//  forms the 16 separable weights wx[i]*wy[j], multiplies each texel, rounds and saturates.
//  Emits the signed weighted texel matrix over valid/ready to the summing/clamping stage.
//  Matrix indexing matches that stage: [i] = horizontal tap, [j] = vertical tap.
// PARAMETERS
//  COLOR_WIDTH                 8   unsigned texel width
//  WEIGHT_WIDTH                10  signed tap-weight width
//  WEIGHT_FRACT_WIDTH          8   fractional bits of each weight (256 = 1.0)
//  WEIGHTED_COLOR_WIDTH        16  signed output width
//  WEIGHTED_COLOR_FRACT_WIDTH  6   fractional bits of output (must be < 2*WEIGHT_FRACT_WIDTH)
// PORTS
//  clk                      in   1                        clock
//  nreset                   in   1                        reset, asynchronous, active-low
//  clr                      in   1                        synchronous flush of all valids
//  in_valid                 in   1                        input beat valid
//  in_ready                 out  1                        input beat accepted when in_valid&in_ready
//  in_texel_matrix[4][4]    in   COLOR_WIDTH              texels
//  in_weights_x[4]          in   WEIGHT_WIDTH (signed)    horizontal taps
//  in_weights_y[4]          in   WEIGHT_WIDTH (signed)    vertical taps
//  out_valid                out  1                        output beat valid
//  out_ready                in   1                        downstream accepts
//  out_weighted_texel_matrix[4][4] out WEIGHTED_COLOR_WIDTH (signed) result
// BEHAVIOUR
//  - Reset: in_ready=1, out_valid=0, all data registers 0, skid buffer empty.
//  - Skid: in_ready is registered; one-beat side buffer absorbs the beat accepted in the cycle
//    en falls. in_ready=0 while side buffer full; side buffer drains first when en returns.
//  - Pipeline enable en = out_ready | ~out_valid (bubbles collapse). Two substages:
//    A: latch texels, w[i][j] = wx[i]*wy[j] (2*WEIGHT_WIDTH signed, 2*WFW fract bits).
//    B: p = texel*w (zero-extend texel), round half-up: add 1<<(2*WFW-WCFW-1), arith shift right
//       by 2*WFW-WCFW; saturate to signed WEIGHTED_COLOR_WIDTH range; register to output.
//  - Latency: accepted beat presents on out 2 cycles later with out_ready held high; throughput 1/clk.
//  - out_valid & !out_ready: output data and out_valid held stable until accepted.
//  - clr: all valids cleared, side buffer emptied, in_ready=1 next cycle; data regs untouched.
//    clr and in_valid same cycle: beat dropped.
//  - Reset mid-stream: in-flight beats discarded, no partial output.
//  - Saturation per element independent; negative results valid (downstream clamps to 0).
// CONFIGURATION
//  DC_IPU_FILTER_S0_BYPASS_EN defined: extra input in_bypass (1 bit, sampled with beat); when 1
//   weights are forced to w[1][1]=1.0, all others 0 (nearest-neighbour), in_weights_* ignored.
//  Undefined: no in_bypass port; weights always from in_weights_*.
// STRUCTURE
//  - dc_ipu_filter_pkg: width localparams, rounding-offset constant, saturate function,
//    typedefs for texel/weight/weighted-texel matrices (shared with summing stage).
//  - Sub-module dc_ipu_filter_tap_mul: one tap (substage B multiply, round, saturate), 16 instances.
//  - Skid buffer, valid chain and weight outer product inline.
// TESTING
//  - Identity: wx=wy={0,256,0,0}, texel[1][1]=200, others 255 -> out[1][1]=12800, all others 0.
//  - Negative tap: wx[0]=-32, wy[1]=256, texel[0][1]=255 -> out[0][1]=-2040.
//  - Saturation: all weights 511, texels 255 -> every out = 32767; texel 0 -> 0.
//  - Rounding: texel 255, wx=wy=3 on one tap -> 2; texel 1, wx=wy=1 -> 0.
//  - Backpressure: 8-beat stream, out_ready low 3 cycles mid-stream -> all 8 out in order,
//    none lost/duplicated, in_ready low only while side buffer full, out data stable while stalled.
//  - clr with 2 beats in flight -> out_valid=0 next cycle, in_ready=1; bypass build: in_bypass=1,
//    texel[1][1]=17 -> out[1][1]=1088, others 0.

Source files
------------

// File: rtl/dc_ipu_filter_pkg.sv
// Shared widths, rounding constants, saturation helper and matrix types for the IPU scaler filter.
// Used by the weighting front stage and the downstream summing/clamping stage.
package dc_ipu_filter_pkg;

    localparam int COLOR_WIDTH                = 8;
    localparam int WEIGHT_WIDTH               = 10;
    localparam int WEIGHT_FRACT_WIDTH         = 8;
    localparam int WEIGHTED_COLOR_WIDTH       = 16;
    localparam int WEIGHTED_COLOR_FRACT_WIDTH = 6;

    localparam int PROD_WIDTH  = 2 * WEIGHT_WIDTH;
    localparam int ACC_WIDTH   = COLOR_WIDTH + 1 + PROD_WIDTH + 1;
    localparam int ROUND_SHIFT = 2 * WEIGHT_FRACT_WIDTH - WEIGHTED_COLOR_FRACT_WIDTH;

    localparam logic signed [ACC_WIDTH-1:0] ROUND_OFFSET = ACC_WIDTH'(1) << (ROUND_SHIFT - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (WEIGHTED_COLOR_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-(1 << (WEIGHTED_COLOR_WIDTH - 1)));

    // 1.0 in the outer-product format (2*WEIGHT_FRACT_WIDTH fractional bits)
    localparam logic signed [PROD_WIDTH-1:0] UNIT_WEIGHT = PROD_WIDTH'(1) << (2 * WEIGHT_FRACT_WIDTH);
    localparam logic signed [PROD_WIDTH-1:0] ZERO_WEIGHT = PROD_WIDTH'(0);

    typedef logic        [COLOR_WIDTH-1:0]          texel_matrix_t    [4][4];
    typedef logic signed [WEIGHT_WIDTH-1:0]         weight_vec_t      [4];
    typedef logic signed [PROD_WIDTH-1:0]           weight_matrix_t   [4][4];
    typedef logic signed [WEIGHTED_COLOR_WIDTH-1:0] weighted_matrix_t [4][4];

    function automatic logic signed [WEIGHTED_COLOR_WIDTH-1:0] saturate(
        input logic signed [ACC_WIDTH-1:0] value
    );
        if (value > SAT_MAX)
            return SAT_MAX[WEIGHTED_COLOR_WIDTH-1:0];
        else if (value < SAT_MIN)
            return SAT_MIN[WEIGHTED_COLOR_WIDTH-1:0];
        else
            return value[WEIGHTED_COLOR_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/dc_ipu_filter_tap_mul.sv
// One filter tap: texel times separable weight, round half-up to the output fraction, saturate.
module dc_ipu_filter_tap_mul
    import dc_ipu_filter_pkg::*;
(
    input  logic        [COLOR_WIDTH-1:0]          texel,
    input  logic signed [PROD_WIDTH-1:0]           weight,
    output logic signed [WEIGHTED_COLOR_WIDTH-1:0] result
);

    logic signed [ACC_WIDTH-1:0] product;
    logic signed [ACC_WIDTH-1:0] rounded;

    // Texel is unsigned, so a zero sign bit keeps it positive in the signed multiply
    assign product = $signed({1'b0, texel}) * weight;
    assign rounded = (product + ROUND_OFFSET) >>> ROUND_SHIFT;
    assign result  = saturate(rounded);

endmodule

// File: rtl/dc_ipu_filter_core_s0.sv
// IPU scaler filter front stage: skid-buffered input, weight outer product, 16 tap multipliers.
// Define DC_IPU_FILTER_S0_BYPASS_EN to add the in_bypass nearest-neighbour weight override.
module dc_ipu_filter_core_s0
    import dc_ipu_filter_pkg::*;
(
    input  logic             clk,
    input  logic             nreset,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  texel_matrix_t    in_texel_matrix,
    input  weight_vec_t      in_weights_x,
    input  weight_vec_t      in_weights_y,
`ifdef DC_IPU_FILTER_S0_BYPASS_EN
    input  logic             in_bypass,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output weighted_matrix_t out_weighted_texel_matrix
);

    logic             bypass_in;
    logic             en;
    logic             accept;
    logic             src_valid;
    logic             src_bypass;
    texel_matrix_t    src_texel;
    weight_vec_t      src_wx;
    weight_vec_t      src_wy;
    weight_matrix_t   src_weight;
    weighted_matrix_t tap_result;

    logic             in_ready_reg;
    logic             sb_valid_reg;
    logic             sb_bypass_reg;
    texel_matrix_t    sb_texel_reg;
    weight_vec_t      sb_wx_reg;
    weight_vec_t      sb_wy_reg;
    logic             a_valid_reg;
    texel_matrix_t    a_texel_reg;
    weight_matrix_t   a_weight_reg;
    logic             out_valid_reg;
    weighted_matrix_t out_data_reg;

`ifdef DC_IPU_FILTER_S0_BYPASS_EN
    assign bypass_in = in_bypass;
`else
    assign bypass_in = 1'b0;
`endif

    assign en         = out_ready | ~out_valid_reg;
    assign accept     = in_valid & in_ready_reg;
    // A held side-buffer beat always goes ahead of the live input
    assign src_valid  = sb_valid_reg | accept;
    assign src_bypass = sb_valid_reg ? sb_bypass_reg : bypass_in;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_row
            assign src_wx[gi] = sb_valid_reg ? sb_wx_reg[gi] : in_weights_x[gi];
            assign src_wy[gi] = sb_valid_reg ? sb_wy_reg[gi] : in_weights_y[gi];

            for (genvar gj = 0; gj < 4; gj++) begin : g_col
                localparam logic signed [PROD_WIDTH-1:0] BYPASS_WEIGHT =
                    (gi == 1 && gj == 1) ? UNIT_WEIGHT : ZERO_WEIGHT;
                logic signed [PROD_WIDTH-1:0] outer;

                assign src_texel[gi][gj]  = sb_valid_reg ? sb_texel_reg[gi][gj] : in_texel_matrix[gi][gj];
                assign outer              = src_wx[gi] * src_wy[gj];
                assign src_weight[gi][gj] = src_bypass ? BYPASS_WEIGHT : outer;

                dc_ipu_filter_tap_mul u_tap (
                    .texel  (a_texel_reg[gi][gj]),
                    .weight (a_weight_reg[gi][gj]),
                    .result (tap_result[gi][gj])
                );
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            in_ready_reg  <= 1'b1;
            sb_valid_reg  <= 1'b0;
            sb_bypass_reg <= 1'b0;
            sb_texel_reg  <= '{default: '0};
            sb_wx_reg     <= '{default: '0};
            sb_wy_reg     <= '{default: '0};
            a_valid_reg   <= 1'b0;
            a_texel_reg   <= '{default: '0};
            a_weight_reg  <= '{default: '0};
            out_valid_reg <= 1'b0;
            out_data_reg  <= '{default: '0};
        end else if (clr) begin
            in_ready_reg  <= 1'b1;
            sb_valid_reg  <= 1'b0;
            a_valid_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
        end else if (en) begin
            a_valid_reg   <= src_valid;
            if (src_valid) begin
                a_texel_reg  <= src_texel;
                a_weight_reg <= src_weight;
            end
            out_valid_reg <= a_valid_reg;
            if (a_valid_reg)
                out_data_reg <= tap_result;
            sb_valid_reg  <= 1'b0;
            in_ready_reg  <= 1'b1;
        end else if (accept) begin
            // Pipeline stalled while in_ready was still high: park the beat
            sb_valid_reg  <= 1'b1;
            sb_bypass_reg <= bypass_in;
            sb_texel_reg  <= in_texel_matrix;
            sb_wx_reg     <= in_weights_x;
            sb_wy_reg     <= in_weights_y;
            in_ready_reg  <= 1'b0;
        end
    end

    assign in_ready                  = in_ready_reg;
    assign out_valid                 = out_valid_reg;
    assign out_weighted_texel_matrix = out_data_reg;

endmodule

// File: tb/tb_dc_ipu_filter_core_s0.sv
// Directed bench for dc_ipu_filter_core_s0: single-beat arithmetic vectors, backpressure stream, clr, reset.
module tb_dc_ipu_filter_core_s0;
    import dc_ipu_filter_pkg::*;

    logic             clk = 1'b0;
    logic             nreset = 1'b0;
    logic             clr = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready = 1'b1;
    texel_matrix_t    in_texel_matrix;
    weight_vec_t      in_weights_x;
    weight_vec_t      in_weights_y;
    weighted_matrix_t out_m;
`ifdef DC_IPU_FILTER_S0_BYPASS_EN
    logic             in_bypass = 1'b0;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;
    int exp_m [4][4];

    always #5 clk = ~clk;

    dc_ipu_filter_core_s0 dut (
        .clk                       (clk),
        .nreset                    (nreset),
        .clr                       (clr),
        .in_valid                  (in_valid),
        .in_ready                  (in_ready),
        .in_texel_matrix           (in_texel_matrix),
        .in_weights_x              (in_weights_x),
        .in_weights_y              (in_weights_y),
`ifdef DC_IPU_FILTER_S0_BYPASS_EN
        .in_bypass                 (in_bypass),
`endif
        .out_valid                 (out_valid),
        .out_ready                 (out_ready),
        .out_weighted_texel_matrix (out_m)
    );

    task automatic check(input string tag, input logic signed [31:0] observed,
                         input logic signed [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic set_all(input int tex_val, input int wx_val, input int wy_val);
        for (int i = 0; i < 4; i++) begin
            in_weights_x[i] = WEIGHT_WIDTH'(wx_val);
            in_weights_y[i] = WEIGHT_WIDTH'(wy_val);
            for (int j = 0; j < 4; j++) begin
                in_texel_matrix[i][j] = COLOR_WIDTH'(tex_val);
                exp_m[i][j] = 0;
            end
        end
    endtask

    task automatic run_single(input string name);
        @(negedge clk);
        check({name, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check({name, "_out_valid"}, out_valid, 1);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                check($sformatf("%s[%0d][%0d]", name, i, j), out_m[i][j], exp_m[i][j]);
        $display("txn %s: out_valid=%0d out[1][1]=%0d", name, out_valid, out_m[1][1]);
        @(negedge clk);
        check({name, "_drained"}, out_valid, 0);
    endtask

    task automatic backpressure();
        int idx = 0;
        int low_cnt = 0;
        set_all(0, 0, 0);
        in_weights_x[1] = 10'sd256;
        in_weights_y[1] = 10'sd256;
        @(negedge clk);
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    in_texel_matrix[1][1] = COLOR_WIDTH'(10 * k + 5);
                    in_valid = 1'b1;
                    for (int w = 0; w < 50 && in_ready !== 1'b1; w++)
                        @(negedge clk);
                    @(negedge clk);
                end
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    out_ready = !(c >= 4 && c <= 6);
                    if (in_ready !== 1'b1)
                        low_cnt++;
                    if (out_valid === 1'b1) begin
                        if (idx < 8)
                            check($sformatf("bp_beat%0d", idx), out_m[1][1], (10 * idx + 5) * 64);
                        if (out_ready) begin
                            $display("txn bp beat %0d: out[1][1]=%0d", idx, out_m[1][1]);
                            idx++;
                        end
                    end
                    @(negedge clk);
                end
            end
        join
        check("bp_count", idx, 8);
        check("bp_in_ready_low_cycles", low_cnt, 3);
    endtask

    task automatic clr_test();
        set_all(255, 0, 0);
        in_weights_x[1] = 10'sd256;
        in_weights_y[1] = 10'sd256;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("clr_pre_out_valid", out_valid, 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        in_valid = 1'b0;
        check("clr_out_valid", out_valid, 0);
        check("clr_in_ready", in_ready, 1);
        check("clr_data_kept", out_m[1][1], 16320);
        $display("txn clr: out_valid=%0d in_ready=%0d", out_valid, in_ready);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("clr_no_output%0d", c), out_valid, 0);
        end
    endtask

    task automatic reset_midstream();
        set_all(255, 256, 256);
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #2 nreset = 1'b0;
        #1;
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_in_ready", in_ready, 1);
        check("rst_mid_data", out_m[1][1], 0);
        @(negedge clk);
        nreset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("rst_mid_no_output%0d", c), out_valid, 0);
        end
        $display("txn reset_midstream: out_valid=%0d", out_valid);
    endtask

    initial begin
        set_all(0, 0, 0);
        repeat (2) @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_m[2][2], 0);
        nreset = 1'b1;

        set_all(255, 0, 0);
        in_weights_x[1] = 10'sd256;
        in_weights_y[1] = 10'sd256;
        in_texel_matrix[1][1] = 8'd200;
        exp_m[1][1] = 12800;
        run_single("identity");

        set_all(255, 0, 0);
        in_weights_x[0] = -10'sd32;
        in_weights_y[1] = 10'sd256;
        exp_m[0][1] = -2040;
        run_single("neg_tap");

        set_all(255, 511, 511);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                exp_m[i][j] = 32767;
        run_single("sat_max");

        set_all(0, 511, 511);
        run_single("sat_zero_texel");

        set_all(0, 0, 0);
        in_texel_matrix[2][3] = 8'd255;
        in_weights_x[2] = 10'sd3;
        in_weights_y[3] = 10'sd3;
        exp_m[2][3] = 2;
        run_single("round_up");

        set_all(1, 1, 1);
        run_single("round_small");

`ifdef DC_IPU_FILTER_S0_BYPASS_EN
        set_all(99, 77, -5);
        in_texel_matrix[1][1] = 8'd17;
        in_bypass = 1'b1;
        exp_m[1][1] = 1088;
        run_single("bypass");
        in_bypass = 1'b0;
`endif

        backpressure();
        clr_test();
        reset_midstream();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
